// File: rtl/csr_irq_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and interrupt controller:
// CSR addresses, funct3 codes, FSM encodings and mstatus bit positions.
package csr_irq_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int IRQ_FIELD_LSB    = 16;
    localparam logic [4:0] IRQ_CAUSE_BASE = 5'd16;

    typedef enum logic [1:0] {
        USER_IDLE = 2'd0,
        TAKE      = 2'd1,
        HANDLER   = 2'd2
    } irq_state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    // Register and immediate forms share an operation; zimm arrives pre-extended.
    function automatic csr_op_e decode_op(input logic [2:0] func3);
        csr_op_e op;
        case (func3)
            F3_RW, F3_RWI: op = OP_WRITE;
            F3_RS, F3_RSI: op = OP_SET;
            F3_RC, F3_RCI: op = OP_CLEAR;
            default:       op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/csr_irq_unit_irq_sync.sv
// Two-flop synchroniser for the asynchronous level-sensitive interrupt lines.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next-state of the two synchroniser stages.
    always_comb begin
        meta_d = i_D;
        sync_d = meta_q;
    end

    // Synchroniser flops with synchronous clear.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_Q = sync_q;

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file, 64-bit counters and interrupt-entry FSM for the V32I core.
// Tracks USER/MACHINE mode in lock-step with decode.
module csr_irq_unit
    import csr_irq_unit_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [31:0] HANDLER_RESET = 32'h0000_0100
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_CSR_EN,
    input  logic [11:0]        i_CSR_ADDR,
    input  logic [2:0]         i_FUNC3,
    input  logic [31:0]        i_WDATA,
    output logic [31:0]        o_RDATA,
    input  logic [NUM_IRQ-1:0] i_IRQ_LINES,
    input  logic [31:0]        i_PC,
    input  logic               i_MRET,
    input  logic               i_RETIRE,
    output logic               o_IRQ,
    output logic [31:0]        o_HANDLER_BASE,
    output logic [31:0]        o_MEPC,
    output logic               o_MODE
);

    logic [NUM_IRQ-1:0] mip_s;
    logic [NUM_IRQ-1:0] pend_vec_s;
    logic               pending_s;
    logic [4:0]         cause_idx_s;
    logic [31:0]        trap_cause_s;
    logic [31:0]        rdata_s;
    logic [31:0]        wr_val_s;
    logic               wr_en_s;
    csr_op_e            op_s;
    logic               take_s;
    logic               mret_s;

    irq_state_e         state_d, state_q;
    logic               irq_d, irq_q;
    logic               mode_d, mode_q;
    logic               mstatus_mie_d, mstatus_mie_q;
    logic               mstatus_mpie_d, mstatus_mpie_q;
    logic [NUM_IRQ-1:0] mie_d, mie_q;
    logic [31:0]        mtvec_d, mtvec_q;
    logic [31:0]        mscratch_d, mscratch_q;
    logic [31:0]        mepc_d, mepc_q;
    logic [31:0]        mcause_d, mcause_q;
    logic [63:0]        mcycle_d, mcycle_q;
    logic [63:0]        minstret_d, minstret_q;

    irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_D   (i_IRQ_LINES),
        .o_Q   (mip_s)
    );

    // CSR read mux; unlisted addresses read zero.
    always_comb begin
        rdata_s = 32'h0;
        case (i_CSR_ADDR)
            CSR_MSTATUS: begin
                rdata_s[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                rdata_s[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MIE:                   rdata_s = 32'(mie_q) << IRQ_FIELD_LSB;
            CSR_MTVEC:                 rdata_s = mtvec_q;
            CSR_MSCRATCH:              rdata_s = mscratch_q;
            CSR_MEPC:                  rdata_s = mepc_q;
            CSR_MCAUSE:                rdata_s = mcause_q;
            CSR_MIP:                   rdata_s = 32'(mip_s) << IRQ_FIELD_LSB;
            CSR_MCYCLE, CSR_CYCLE:     rdata_s = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   rdata_s = mcycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET: rdata_s = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata_s = minstret_q[63:32];
            default:                   rdata_s = 32'h0;
        endcase
    end

    // Write value and enable; set/clear with a zero operand is not a write.
    always_comb begin
        op_s = decode_op(i_FUNC3);
        case (op_s)
            OP_WRITE: wr_val_s = i_WDATA;
            OP_SET:   wr_val_s = rdata_s | i_WDATA;
            OP_CLEAR: wr_val_s = rdata_s & ~i_WDATA;
            default:  wr_val_s = rdata_s;
        endcase
        if (op_s == OP_WRITE) begin
            wr_en_s = i_CSR_EN;
        end else if ((op_s == OP_SET) || (op_s == OP_CLEAR)) begin
            wr_en_s = i_CSR_EN && (i_WDATA != 32'h0);
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Pending detection and lowest-index priority encoder.
    always_comb begin
        pend_vec_s  = mip_s & mie_q;
        pending_s   = |pend_vec_s;
        cause_idx_s = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_vec_s[i]) begin
                cause_idx_s = 5'(i);
            end else begin
                cause_idx_s = cause_idx_s;
            end
        end
        trap_cause_s = {1'b1, 26'h0, IRQ_CAUSE_BASE + cause_idx_s};
    end

    // Interrupt FSM next state; o_IRQ and o_MODE are decoded from the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            USER_IDLE: begin
                if (mstatus_mie_q && pending_s) begin
                    state_d = TAKE;
                end else begin
                    state_d = USER_IDLE;
                end
            end
            TAKE:    state_d = HANDLER;
            HANDLER: begin
                if (i_MRET) begin
                    state_d = USER_IDLE;
                end else begin
                    state_d = HANDLER;
                end
            end
            default: state_d = USER_IDLE;
        endcase
        take_s = (state_q == TAKE);
        mret_s = (state_q == HANDLER) && i_MRET;
        irq_d  = (state_d == TAKE);
        mode_d = (state_d != USER_IDLE);
    end

    // CSR next values; trap and mret updates beat same-cycle software writes.
    always_comb begin
        if (take_s) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_s) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en_s && (i_CSR_ADDR == CSR_MSTATUS)) begin
            mstatus_mie_d  = wr_val_s[MSTATUS_MIE_BIT];
            mstatus_mpie_d = wr_val_s[MSTATUS_MPIE_BIT];
        end else begin
            mstatus_mie_d  = mstatus_mie_q;
            mstatus_mpie_d = mstatus_mpie_q;
        end

        if (wr_en_s && (i_CSR_ADDR == CSR_MIE)) begin
            mie_d = wr_val_s[IRQ_FIELD_LSB +: NUM_IRQ];
        end else begin
            mie_d = mie_q;
        end

        if (wr_en_s && (i_CSR_ADDR == CSR_MTVEC)) begin
            mtvec_d = wr_val_s & 32'hFFFF_FFFC;
        end else begin
            mtvec_d = mtvec_q;
        end

        if (wr_en_s && (i_CSR_ADDR == CSR_MSCRATCH)) begin
            mscratch_d = wr_val_s;
        end else begin
            mscratch_d = mscratch_q;
        end

        if (take_s) begin
            mepc_d = i_PC & 32'hFFFF_FFFC;
        end else if (wr_en_s && (i_CSR_ADDR == CSR_MEPC)) begin
            mepc_d = wr_val_s & 32'hFFFF_FFFC;
        end else begin
            mepc_d = mepc_q;
        end

        if (take_s) begin
            mcause_d = trap_cause_s;
        end else if (wr_en_s && (i_CSR_ADDR == CSR_MCAUSE)) begin
            mcause_d = wr_val_s;
        end else begin
            mcause_d = mcause_q;
        end

        if (wr_en_s && (i_CSR_ADDR == CSR_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], wr_val_s};
        end else if (wr_en_s && (i_CSR_ADDR == CSR_MCYCLEH)) begin
            mcycle_d = {wr_val_s, mcycle_q[31:0]};
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end

        if (wr_en_s && (i_CSR_ADDR == CSR_MINSTRET)) begin
            minstret_d = {minstret_q[63:32], wr_val_s};
        end else if (wr_en_s && (i_CSR_ADDR == CSR_MINSTRETH)) begin
            minstret_d = {wr_val_s, minstret_q[31:0]};
        end else if (i_RETIRE) begin
            minstret_d = minstret_q + 64'd1;
        end else begin
            minstret_d = minstret_q;
        end
    end

    // Interrupt FSM state and its registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= USER_IDLE;
            irq_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            mode_q  <= mode_d;
        end
    end

    // CSR and counter storage.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= HANDLER_RESET;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign o_RDATA        = rdata_s;
    assign o_IRQ          = irq_q;
    assign o_MODE         = mode_q;
    assign o_HANDLER_BASE = mtvec_q;
    assign o_MEPC         = mepc_q;

endmodule

// File: tb/tb_csr_irq_unit.sv
// Scoreboard bench for csr_irq_unit: stimulus queues expected values, a negedge monitor compares.
module tb_csr_irq_unit;

    logic        i_CLK;
    logic        i_RST;
    logic        i_CSR_EN;
    logic [11:0] i_CSR_ADDR;
    logic [2:0]  i_FUNC3;
    logic [31:0] i_WDATA;
    logic [31:0] o_RDATA;
    logic [3:0]  i_IRQ_LINES;
    logic [31:0] i_PC;
    logic        i_MRET;
    logic        i_RETIRE;
    logic        o_IRQ;
    logic [31:0] o_HANDLER_BASE;
    logic [31:0] o_MEPC;
    logic        o_MODE;

    localparam int K_RDATA = 0;
    localparam int K_MODE  = 1;
    localparam int K_HBASE = 2;
    localparam int K_MEPC  = 3;
    localparam int K_IRQ   = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        chk_q[$];
    int          irq_exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    chk_t        mon_c;
    logic [31:0] mon_act;
    int          mon_due;

    csr_irq_unit dut (
        .i_CLK          (i_CLK),
        .i_RST          (i_RST),
        .i_CSR_EN       (i_CSR_EN),
        .i_CSR_ADDR     (i_CSR_ADDR),
        .i_FUNC3        (i_FUNC3),
        .i_WDATA        (i_WDATA),
        .o_RDATA        (o_RDATA),
        .i_IRQ_LINES    (i_IRQ_LINES),
        .i_PC           (i_PC),
        .i_MRET         (i_MRET),
        .i_RETIRE       (i_RETIRE),
        .o_IRQ          (o_IRQ),
        .o_HANDLER_BASE (o_HANDLER_BASE),
        .o_MEPC         (o_MEPC),
        .o_MODE         (o_MODE)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    always @(posedge i_CLK) cyc <= cyc + 1;

    // Monitor: retire every expectation due this cycle and account for each o_IRQ pulse.
    always @(negedge i_CLK) begin
        while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
            mon_c = chk_q.pop_front();
            case (mon_c.kind)
                K_RDATA: mon_act = o_RDATA;
                K_MODE:  mon_act = {31'h0, o_MODE};
                K_HBASE: mon_act = o_HANDLER_BASE;
                K_MEPC:  mon_act = o_MEPC;
                K_IRQ:   mon_act = {31'h0, o_IRQ};
                default: mon_act = 32'hxxxx_xxxx;
            endcase
            checks++;
            if (mon_c.due != cyc || mon_act !== mon_c.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, due %0d)",
                         mon_c.name, mon_act, mon_c.exp, cyc, mon_c.due);
            end
        end
        if (o_IRQ === 1'b1) begin
            checks++;
            if (irq_exp_q.size() == 0) begin
                failures++;
                $display("FAIL irq_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_due = irq_exp_q.pop_front();
                if (mon_due != cyc) begin
                    failures++;
                    $display("FAIL irq_timing: got pulse at cycle %0d expected cycle %0d", cyc, mon_due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic chk(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.due  = cyc;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        i_CSR_EN   = 1'b0;
        i_CSR_ADDR = addr;
        chk(K_RDATA, exp, name);
        tick();
    endtask

    task automatic wr(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] data);
        i_CSR_EN   = 1'b1;
        i_FUNC3    = f3;
        i_CSR_ADDR = addr;
        i_WDATA    = data;
        tick();
        i_CSR_EN   = 1'b0;
    endtask

    initial begin
        int t0;
        i_RST       = 1'b1;
        i_CSR_EN    = 1'b0;
        i_CSR_ADDR  = 12'h000;
        i_FUNC3     = 3'b000;
        i_WDATA     = 32'h0;
        i_IRQ_LINES = 4'b0000;
        i_PC        = 32'h0;
        i_MRET      = 1'b0;
        i_RETIRE    = 1'b0;

        tick();
        tick();
        chk(K_HBASE, 32'h0000_0100, "reset_handler_base");
        chk(K_MEPC,  32'h0,         "reset_mepc");
        chk(K_IRQ,   32'h0,         "reset_irq");
        chk(K_MODE,  32'h0,         "reset_mode");
        rd(12'h300, 32'h0, "reset_mstatus");
        i_RST = 1'b0;

        // CSR read-modify-write operations on mscratch.
        wr(3'b001, 12'h340, 32'hDEAD_BEEF);
        wr(3'b010, 12'h340, 32'h0000_0F00);
        rd(12'h340, 32'hDEAD_BFEF, "rs_mscratch");
        wr(3'b011, 12'h340, 32'hFFFF_0000);
        rd(12'h340, 32'h0000_BFEF, "rc_mscratch");
        wr(3'b010, 12'h340, 32'h0);
        rd(12'h340, 32'h0000_BFEF, "rs_zero_nowrite");
        wr(3'b101, 12'h340, 32'h0000_0015);
        i_CSR_EN = 1'b1; i_FUNC3 = 3'b001; i_CSR_ADDR = 12'h340; i_WDATA = 32'h1234_5678;
        chk(K_RDATA, 32'h0000_0015, "rdata_prewrite");
        tick();
        i_CSR_EN = 1'b0;
        rd(12'h340, 32'h1234_5678, "rw_mscratch");
        wr(3'b001, 12'h305, 32'h0000_0203);
        chk(K_HBASE, 32'h0000_0200, "mtvec_out");
        rd(12'h305, 32'h0000_0200, "mtvec_low_bits");
        wr(3'b001, 12'h7C0, 32'h0000_FFFF);
        rd(12'h7C0, 32'h0, "unlisted_addr");
        wr(3'b001, 12'h344, 32'hFFFF_FFFF);
        rd(12'h344, 32'h0, "mip_readonly");
        wr(3'b001, 12'h300, 32'hFFFF_FFFF);
        rd(12'h300, 32'h0000_0088, "mstatus_mask");

        // Trap entry with lines 1 and 0 raised together.
        wr(3'b001, 12'h304, 32'h0003_0000);
        wr(3'b001, 12'h300, 32'h0000_0008);
        i_PC = 32'h0000_0040;
        i_IRQ_LINES = 4'b0011;
        irq_exp_q.push_back(cyc + 3);
        tick(); tick(); tick();
        tick();
        chk(K_MODE, 32'h1, "mode_handler");
        chk(K_MEPC, 32'h0000_0040, "mepc_out");
        rd(12'h341, 32'h0000_0040, "mepc_csr");
        rd(12'h342, 32'h8000_0010, "mcause_lowest");
        rd(12'h300, 32'h0000_0080, "mstatus_in_handler");
        rd(12'h344, 32'h0003_0000, "mip_lines");
        tick(); tick(); tick(); tick();

        // mret re-enables and the still-high line traps again; software mstatus write in TAKE loses.
        i_PC = 32'h0000_0080;
        i_MRET = 1'b1;
        tick();
        i_MRET = 1'b0;
        irq_exp_q.push_back(cyc + 1);
        chk(K_MODE, 32'h0, "mode_after_mret");
        rd(12'h300, 32'h0000_0088, "mstatus_after_mret");
        i_CSR_EN = 1'b1; i_FUNC3 = 3'b001; i_CSR_ADDR = 12'h300; i_WDATA = 32'h0000_0008;
        chk(K_RDATA, 32'h0000_0088, "rdata_in_take");
        tick();
        i_CSR_EN = 1'b0;
        chk(K_MODE, 32'h1, "mode_second_trap");
        rd(12'h300, 32'h0000_0080, "trap_beats_write");
        rd(12'h341, 32'h0000_0080, "mepc_second_trap");

        i_IRQ_LINES = 4'b0000;
        tick(); tick(); tick();
        i_MRET = 1'b1;
        tick();
        i_MRET = 1'b0;
        chk(K_MODE, 32'h0, "mode_idle_again");
        rd(12'h300, 32'h0000_0088, "mstatus_restored");
        tick(); tick();

        // Reset asserted during TAKE.
        i_IRQ_LINES = 4'b0010;
        irq_exp_q.push_back(cyc + 3);
        tick(); tick(); tick();
        i_RST = 1'b1;
        tick();
        i_IRQ_LINES = 4'b0000;
        chk(K_MODE,  32'h0,         "rst_take_mode");
        chk(K_MEPC,  32'h0,         "rst_take_mepc");
        chk(K_HBASE, 32'h0000_0100, "rst_take_hbase");
        chk(K_IRQ,   32'h0,         "rst_take_irq");
        rd(12'h342, 32'h0, "rst_take_mcause");
        rd(12'h300, 32'h0, "rst_take_mstatus");
        i_RST = 1'b0;

        // Counter wrap, write precedence and read-only aliases.
        wr(3'b001, 12'hB80, 32'hFFFF_FFFF);
        wr(3'b001, 12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle_written");
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_inc");
        rd(12'hB00, 32'h0, "mcycle_wrap_lo");
        rd(12'hB80, 32'h0, "mcycle_wrap_hi");
        rd(12'hC00, 32'h0000_0002, "cycle_alias");
        wr(3'b001, 12'hB00, 32'h0000_1000);
        rd(12'hB00, 32'h0000_1000, "mcycle_write_wins");
        i_RETIRE = 1'b1;
        t0 = 3;
        for (int i = 0; i < t0; i++) tick();
        i_RETIRE = 1'b0;
        rd(12'hB02, 32'h0000_0003, "minstret_count");
        wr(3'b001, 12'hC02, 32'h0000_0055);
        rd(12'hC02, 32'h0000_0003, "instret_readonly");
        rd(12'hB82, 32'h0, "minstreth");

        tick(); tick(); tick();
        while (irq_exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL irq_missing: got no pulse expected one at cycle %0d", irq_exp_q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
